nco_sequencer: RTL and testbench

Note sequencer that drives the NCO's phaseinc, enable and waveform-select inputs from a small programmable table of (phase increment, duration, waveform) entries. It replaces the static switch-to-phaseinc path so the audio output can play timed tone sequences. It contains its own tick prescaler, which generates the note-duration time base from the system clock. It sits between the configuration/switch logic and the NCO, in the CLK_100M domain.

---
 rtl/nco_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_nco_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nco_sequencer.sv
// Table-driven note sequencer feeding the NCO phaseinc/enable/waveform inputs.
// Optional inter-note silence is built when NCO_SEQ_GAP_EN is defined.
//   state | meaning
//   IDLE  | no playback, outputs cleared
//   LOAD  | read table[idx], start note or finish on an end marker
//   PLAY  | hold note until dur ticks have elapsed
//   GAP   | silent ticks between notes (NCO_SEQ_GAP_EN only)
module nco_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int DUR_W     = 16,
  parameter int TICK_DIV  = 32768,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [7:0]       wr_phaseinc,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             wr_sel,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [AW-1:0]    last_idx,
  output logic             nco_enable,
  output logic [7:0]       phaseinc,
  output logic             wave_sel,
  output logic             busy,
  output logic [AW-1:0]    cur_idx,
  output logic             done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [AW-1:0]    idx_q, idx_d, last_q, last_d, cur_q, cur_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             en_q, en_d, sel_q, sel_d, done_q, done_d;
  logic [7:0]       pinc_q, pinc_d;
  logic             tick;

  logic [7:0]       tbl_pinc [DEPTH];
  logic [DUR_W-1:0] tbl_dur  [DEPTH];
  logic             tbl_sel  [DEPTH];
  logic [7:0]       rd_pinc;
  logic [DUR_W-1:0] rd_dur;
  logic             rd_sel;

`ifdef NCO_SEQ_GAP_EN
  logic [31:0] gap_q, gap_d;
`else
  logic unused_gap;
  assign unused_gap = |32'(GAP_TICKS);
`endif

  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // Table has no reset; a write in the LOAD cycle lands after the read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_pinc[wr_addr] <= wr_phaseinc;
      tbl_dur[wr_addr]  <= wr_dur;
      tbl_sel[wr_addr]  <= wr_sel;
    end
  end

  assign rd_pinc = tbl_pinc[idx_q];
  assign rd_dur  = tbl_dur[idx_q];
  assign rd_sel  = tbl_sel[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cur_d   = cur_q;
    dur_d   = dur_q;
    en_d    = en_q;
    pinc_d  = pinc_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
`ifdef NCO_SEQ_GAP_EN
    gap_d   = gap_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      pinc_d  = '0;
      sel_d   = 1'b0;
      cur_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            idx_d   = '0;
            last_d  = last_idx;
          end
        end
        S_LOAD: begin
          if (rd_dur == '0) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            pinc_d  = '0;
            sel_d   = 1'b0;
            cur_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = S_PLAY;
            pinc_d  = rd_pinc;
            sel_d   = rd_sel;
            cur_d   = idx_q;
            en_d    = 1'b1;
            dur_d   = rd_dur;
          end
        end
        S_PLAY: begin
          if (tick) begin
            dur_d = dur_q - DUR_W'(1);
            if (dur_q == DUR_W'(1)) begin
              if ((idx_q != last_q) || loop) begin
                idx_d = (idx_q == last_q) ? '0 : idx_q + 1'b1;
`ifdef NCO_SEQ_GAP_EN
                state_d = S_GAP;
                en_d    = 1'b0;
                gap_d   = 32'(GAP_TICKS);
`else
                state_d = S_LOAD;
`endif
              end else begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                pinc_d  = '0;
                sel_d   = 1'b0;
                cur_d   = '0;
                done_d  = 1'b1;
              end
            end
          end
        end
`ifdef NCO_SEQ_GAP_EN
        S_GAP: begin
          if (tick) begin
            gap_d = gap_q - 32'd1;
            if (gap_q == 32'd1) state_d = S_LOAD;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      cur_q   <= '0;
      dur_q   <= '0;
      en_q    <= 1'b0;
      pinc_q  <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef NCO_SEQ_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      dur_q   <= dur_d;
      en_q    <= en_d;
      pinc_q  <= pinc_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
`ifdef NCO_SEQ_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign nco_enable = en_q;
  assign phaseinc   = pinc_q;
  assign wave_sel   = sel_q;
  assign busy       = (state_q != S_IDLE);
  assign cur_idx    = cur_q;
  assign done       = done_q;

endmodule

// File: tb/tb_nco_sequencer.sv
// Randomized bench for nco_sequencer against a tick-schedule reference model.
module tb_nco_sequencer;
  localparam int TD    = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_phaseinc = '0;
  logic [15:0] wr_dur = '0;
  logic        wr_sel = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [3:0]  last_idx = '0;
  logic        nco_enable, wave_sel, busy, done;
  logic [7:0]  phaseinc;
  logic [3:0]  cur_idx;

  nco_sequencer #(.DEPTH(DEPTH), .AW(4), .DUR_W(16), .TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_phaseinc(wr_phaseinc), .wr_dur(wr_dur), .wr_sel(wr_sel),
    .start(start), .stop(stop), .loop(loop), .last_idx(last_idx),
    .nco_enable(nco_enable), .phaseinc(phaseinc), .wave_sel(wave_sel),
    .busy(busy), .cur_idx(cur_idx), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: notes are scheduled by absolute edge number. The prescaler
  // ticks on every edge n with n % TD == 0 (n counted from reset release).
  int         t_pinc [DEPTH];
  int         t_dur  [DEPTH];
  int         t_sel  [DEPTH];
  int         n_edge = 0;
  int         m_mode = 0;   // 0 idle, 1 load, 2 play, 3 gap
  int         m_idx = 0, m_last = 0, m_end = 0, m_cur = 0;
  logic       m_en = 1'b0, m_sel = 1'b0, m_done = 1'b0;
  logic [7:0] m_pinc = '0;

  function automatic int first_tick_after(input int e);
    return (e / TD + 1) * TD;
  endfunction

  task automatic m_clear();
    m_mode = 0; m_en = 1'b0; m_pinc = '0; m_sel = 1'b0; m_cur = 0;
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n_edge = 0; m_done = 1'b0; m_idx = 0; m_last = 0;
      m_clear();
    end else begin
      n_edge++;
      m_done = 1'b0;
      if (stop) m_clear();
      else begin
        case (m_mode)
          0: if (start) begin m_mode = 1; m_idx = 0; m_last = int'(last_idx); end
          1: begin
            if (t_dur[m_idx] == 0) begin m_clear(); m_done = 1'b1; end
            else begin
              m_pinc = 8'(t_pinc[m_idx]); m_sel = t_sel[m_idx][0];
              m_cur = m_idx; m_en = 1'b1; m_mode = 2;
              m_end = first_tick_after(n_edge) + (t_dur[m_idx] - 1) * TD;
            end
          end
          2: if (n_edge == m_end) begin
            if (m_idx != m_last || loop) begin
              m_idx = (m_idx == m_last) ? 0 : (m_idx + 1) % DEPTH;
`ifdef NCO_SEQ_GAP_EN
              m_mode = 3; m_en = 1'b0;
              m_end = first_tick_after(n_edge) + (GAP - 1) * TD;
`else
              m_mode = 1;
`endif
            end else begin
              m_clear(); m_done = 1'b1;
            end
          end
          3: if (n_edge == m_end) m_mode = 1;
          default: m_clear();
        endcase
      end
      if (wr_en) begin
        t_pinc[wr_addr] = int'(wr_phaseinc);
        t_dur[wr_addr]  = int'(wr_dur);
        t_sel[wr_addr]  = int'(wr_sel);
      end
    end
    #1;
    chk("outs", {16'h0, nco_enable, phaseinc, wave_sel, busy, cur_idx, done},
        {16'h0, m_en, m_pinc, m_sel, (m_mode != 0), 4'(m_cur), m_done});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int p, input int d, input int s);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_phaseinc = 8'(p); wr_dur = 16'(d); wr_sel = s[0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) wr(a, 0, 0, 0);

    // two-note one-shot
    wr(0, 'h10, 2, 1); wr(1, 'h20, 1, 0);
    last_idx = 4'd1; loop = 1'b0;
    pulse_start(); cyc(20);

    // looping, then stop mid-note
    loop = 1'b1;
    pulse_start(); cyc(31);
    pulse_stop(); cyc(4);
    loop = 1'b0;

    // end marker before last_idx
    wr(0, 'h33, 3, 0); wr(1, 0, 0, 0);
    last_idx = 4'd5;
    pulse_start(); cyc(20);

    // start+stop together from idle
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    cyc(3);

    // start while playing is ignored
    wr(0, 'h10, 2, 1); wr(1, 'h20, 1, 0); last_idx = 4'd1;
    pulse_start(); cyc(4);
    pulse_start(); cyc(15);

    // rewrite next entry during playback
    pulse_start(); cyc(3);
    wr(1, 'h7F, 1, 0); cyc(15);

    // asynchronous reset mid-note
    pulse_start(); cyc(5);
    #2 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    // randomized sequences
    repeat (40) begin
      for (int k = 0; k < 6; k++)
        wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
           ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3), $urandom_range(0, 1));
      @(negedge clk);
      last_idx = 4'($urandom_range(0, DEPTH - 1));
      loop = 1'($urandom_range(0, 3) == 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < int'($urandom_range(60, 150)); c++) begin
        stop  = ($urandom_range(0, 99) < 2);
        start = ($urandom_range(0, 99) < 4);
        wr_en = ($urandom_range(0, 99) < 5);
        wr_addr = 4'($urandom_range(0, DEPTH - 1));
        wr_phaseinc = 8'($urandom_range(0, 255));
        wr_dur = 16'($urandom_range(0, 3));
        wr_sel = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 29) == 0) loop = ~loop;
        @(negedge clk);
      end
      start = 1'b0; wr_en = 1'b0;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      cyc(2);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
